// File: rtl/gcd_engine.sv
// GCD engine: subtractive Euclid or binary (Stein) GCD, one reduction step per cycle,
// with valid/ready handshakes on operand intake and result delivery.
module gcd_engine #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x_i,
  input  logic [WIDTH-1:0]  y_i,
  input  logic              mode_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  gcd_o,
  output logic [ITER_W-1:0] iter_o,
  output logic              zero_o,
  output logic              busy
);
  localparam int KW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic              m_q, m_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  gcd_q, gcd_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              zero_q, zero_d;

  logic              terminal;
  logic [WIDTH-1:0]  x_or_y;
  logic [ITER_W-1:0] cnt_inc;

  assign terminal = (x_q == '0) || (y_q == '0) || (x_q == y_q);
  assign x_or_y   = x_q | y_q;
  // Step count sticks at all-ones instead of wrapping.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + ITER_W'(1);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    m_d     = m_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    gcd_d   = gcd_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_i;
          y_d     = y_i;
          m_d     = mode_i;
          k_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (terminal) begin
          gcd_d   = x_or_y << k_q;
          iter_d  = cnt_q;
          zero_d  = (x_or_y == '0);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (!m_q) begin
            if (x_q > y_q) x_d = x_q - y_q;
            else           y_d = y_q - x_q;
          end else if (!x_q[0] && !y_q[0]) begin
            x_d = x_q >> 1;
            y_d = y_q >> 1;
            k_d = k_q + KW'(1);
          end else if (!x_q[0]) begin
            x_d = x_q >> 1;
          end else if (!y_q[0]) begin
            y_d = y_q >> 1;
          end else begin
            if (x_q > y_q) x_d = x_q - y_q;
            else           y_d = y_q - x_q;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      m_q     <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      m_q     <= m_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      gcd_q   <= gcd_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign gcd_o     = gcd_q;
  assign iter_o    = iter_q;
  assign zero_o    = zero_q;
endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: table of operand/result records plus
// hand-written backpressure and mid-computation reset sequences.
module tb_gcd_engine;
  localparam int WIDTH  = 8;
  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x_i, y_i;
  logic              mode_i;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  gcd_o;
  logic [ITER_W-1:0] iter_o;
  logic              zero_o;
  logic              busy;

  int total = 0;
  int bad   = 0;

  gcd_engine #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .y_i(y_i), .mode_i(mode_i), .out_valid(out_valid),
    .out_ready(out_ready), .gcd_o(gcd_o), .iter_o(iter_o), .zero_o(zero_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic              m;
    logic [WIDTH-1:0]  g;
    logic [ITER_W-1:0] it;
    logic              z;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents operands, counts edges from acceptance to out_valid, leaves engine in DONE.
  task automatic start_and_wait(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic m, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    x_i = x; y_i = y; mode_i = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_i = 8'hA5; y_i = 8'h5A; mode_i = ~m;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL timeout: out_valid never rose for x=%0d y=%0d", x, y);
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0]  g_hold;
    logic [ITER_W-1:0] it_hold;

    vecs[0]  = '{x: 12,  y: 18, m: 0, g: 6,  it: 2,   z: 0};
    vecs[1]  = '{x: 12,  y: 18, m: 1, g: 6,  it: 4,   z: 0};
    vecs[2]  = '{x: 255, y: 1,  m: 0, g: 1,  it: 254, z: 0};
    vecs[3]  = '{x: 255, y: 1,  m: 1, g: 1,  it: 14,  z: 0};
    vecs[4]  = '{x: 0,   y: 0,  m: 0, g: 0,  it: 0,   z: 1};
    vecs[5]  = '{x: 0,   y: 9,  m: 0, g: 9,  it: 0,   z: 0};
    vecs[6]  = '{x: 7,   y: 7,  m: 1, g: 7,  it: 0,   z: 0};
    vecs[7]  = '{x: 9,   y: 0,  m: 1, g: 9,  it: 0,   z: 0};
    vecs[8]  = '{x: 5,   y: 3,  m: 0, g: 1,  it: 3,   z: 0};
    vecs[9]  = '{x: 8,   y: 12, m: 1, g: 4,  it: 5,   z: 0};
    vecs[10] = '{x: 48,  y: 36, m: 1, g: 12, it: 6,   z: 0};
    vecs[11] = '{x: 0,   y: 0,  m: 1, g: 0,  it: 0,   z: 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_i = '0; y_i = '0; mode_i = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_gcd", gcd_o, 0);
    check("rst_iter", iter_o, 0);
    check("rst_zero", zero_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start_and_wait(vecs[i].x, vecs[i].y, vecs[i].m, lat);
      check($sformatf("lat[%0d]", i), lat, 32'(vecs[i].it) + 1);
      check($sformatf("gcd[%0d]", i), gcd_o, vecs[i].g);
      check($sformatf("iter[%0d]", i), iter_o, vecs[i].it);
      check($sformatf("zero[%0d]", i), zero_o, vecs[i].z);
      check($sformatf("busy_done[%0d]", i), busy, 0);
      release_result();
      check($sformatf("retain_gcd[%0d]", i), gcd_o, vecs[i].g);
      check($sformatf("retain_iter[%0d]", i), iter_o, vecs[i].it);
    end

    // Busy during RUN
    @(negedge clk);
    x_i = 200; y_i = 3; mode_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_run", busy, 1);
    check("in_ready_in_run", in_ready, 0);
    while (!out_valid) begin @(posedge clk); #1; end
    check("gcd_200_3", gcd_o, 1);

    // Backpressure: hold DONE five cycles with new operands offered
    g_hold = gcd_o; it_hold = iter_o;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; x_i = 8'd40 + 8'(c); y_i = 8'd6; mode_i = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_gcd", gcd_o, g_hold);
      check("bp_iter", iter_o, it_hold);
      check("bp_zero", zero_o, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    check("bp_no_accept", busy, 0);

    // Reset mid-computation, then a clean operation
    start_and_wait(8'd0, 8'd5, 1'b0, lat);
    release_result();
    @(negedge clk);
    x_i = 200; y_i = 3; mode_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_gcd", gcd_o, 0);
    check("abort_iter", iter_o, 0);
    check("abort_zero", zero_o, 0);
    @(negedge clk);
    rst = 1'b0;
    start_and_wait(8'd48, 8'd36, 1'b1, lat);
    check("post_rst_lat", lat, 7);
    check("post_rst_gcd", gcd_o, 12);
    check("post_rst_iter", iter_o, 6);
    check("post_rst_zero", zero_o, 0);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
